topk_drain: RTL and testbench

Downstream consumer of the top-K insertion sorter. On the sorter's result pulse it snapshots all K sorted (data, index) pairs and, one cycle later, the per-block row counts. It then serialises the K entries onto a valid/ready stream toward the result writer/DMA. While draining it signals busy so the controller holds off the next row.

---
 rtl/topk_drain_pkg.sv | 23 ++
 rtl/topk_drain.sv | 127 ++++++++++++
 tb/tb_topk_drain.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/topk_drain_pkg.sv
`default_nettype none
// ============================================================================
// Module      : topk_drain_pkg
// Description : Shared widths and drain FSM encoding for the top-K result path.
// Revision    : 1.0 - initial release
// ============================================================================
package topk_drain_pkg;

  localparam int DEF_K_NUMBER     = 32;
  localparam int DEF_LOG2_K       = 5;
  localparam int DEF_DATA_WIDTH   = 4;
  localparam int DEF_INDEX_WIDTH  = 9;
  localparam int DEF_BLOCK_NUMBER = 16;
  localparam int DEF_LOG2_WIDTH   = 5;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CAPT_CNT = 2'd1,
    ST_STREAM   = 2'd2
  } drain_state_t;

endpackage
`default_nettype wire

// File: rtl/topk_drain.sv
`default_nettype none
// ============================================================================
// Module      : topk_drain
// Description : Snapshots a sorted top-K result and streams it out entry by entry.
// Revision    : 1.0 - initial release
// ============================================================================
module topk_drain
  import topk_drain_pkg::*;
#(
  parameter int K_NUMBER     = DEF_K_NUMBER,
  parameter int LOG2_K       = DEF_LOG2_K,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int INDEX_WIDTH  = DEF_INDEX_WIDTH,
  parameter int BLOCK_NUMBER = DEF_BLOCK_NUMBER,
  parameter int LOG2_WIDTH   = DEF_LOG2_WIDTH
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     i_valid,
  input  logic [DATA_WIDTH*K_NUMBER-1:0]           i_sorted_data,
  input  logic [INDEX_WIDTH*K_NUMBER-1:0]          i_sorted_index,
  input  logic                                     i_count_valid,
  input  logic [BLOCK_NUMBER*(LOG2_WIDTH+1)-1:0]   i_row_block_count,
  input  logic                                     i_ready,
  output logic                                     o_valid,
  output logic [DATA_WIDTH-1:0]                    o_data,
  output logic [INDEX_WIDTH-1:0]                   o_index,
  output logic                                     o_last,
  output logic                                     o_busy,
  output logic [BLOCK_NUMBER*(LOG2_WIDTH+1)-1:0]   o_row_block_count,
  output logic                                     o_count_valid,
  output logic                                     o_overrun,
  output logic                                     o_count_err
);

  localparam int CNT_W = BLOCK_NUMBER*(LOG2_WIDTH+1);
  localparam logic [LOG2_K-1:0] c_last_ptr = LOG2_K'(K_NUMBER-1);

  drain_state_t r_state;
  drain_state_t w_state_nxt;

  logic [LOG2_K-1:0]               r_ptr;
  logic [DATA_WIDTH*K_NUMBER-1:0]  r_data_snap;
  logic [INDEX_WIDTH*K_NUMBER-1:0] r_index_snap;
  logic [CNT_W-1:0]                r_row_block_count;
  logic                            r_count_valid;
  logic                            r_overrun;
  logic                            r_count_err;

  logic                            w_streaming;
  logic                            w_is_last;
  logic [DATA_WIDTH-1:0]           w_data_arr  [K_NUMBER];
  logic [INDEX_WIDTH-1:0]          w_index_arr [K_NUMBER];

  // Unpack the flat snapshots so the pointer can select one entry directly.
  generate
    for (genvar e = 0; e < K_NUMBER; e++) begin : g_entry
      assign w_data_arr[e]  = r_data_snap[e*DATA_WIDTH +: DATA_WIDTH];
      assign w_index_arr[e] = r_index_snap[e*INDEX_WIDTH +: INDEX_WIDTH];
    end
  endgenerate

  assign w_streaming = (r_state == ST_STREAM);
  assign w_is_last   = (r_ptr == c_last_ptr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:     if (i_valid) w_state_nxt = ST_CAPT_CNT;
      ST_CAPT_CNT: w_state_nxt = ST_STREAM;
      ST_STREAM:   if (i_ready && w_is_last) w_state_nxt = ST_IDLE;
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr             <= '0;
      r_data_snap       <= '0;
      r_index_snap      <= '0;
      r_row_block_count <= '0;
      r_count_valid     <= 1'b0;
      r_overrun         <= 1'b0;
      r_count_err       <= 1'b0;
    end else begin
      r_count_valid <= 1'b0;
      if (i_valid) begin
        if (r_state == ST_IDLE) begin
          r_data_snap  <= i_sorted_data;
          r_index_snap <= i_sorted_index;
        end else begin
          r_overrun <= 1'b1;
        end
      end
      if (r_state == ST_CAPT_CNT) begin
        r_row_block_count <= i_row_block_count;
        r_count_valid     <= 1'b1;
        r_ptr             <= '0;
        if (!i_count_valid) r_count_err <= 1'b1;
      end
      if (w_streaming && i_ready) begin
        r_ptr <= w_is_last ? '0 : r_ptr + LOG2_K'(1);
      end
    end
  end

  // Stream outputs come from state and pointer only, never from i_ready.
  assign o_valid           = w_streaming;
  assign o_data            = w_streaming ? w_data_arr[r_ptr]  : '0;
  assign o_index           = w_streaming ? w_index_arr[r_ptr] : '0;
  assign o_last            = w_streaming && w_is_last;
  assign o_busy            = (r_state != ST_IDLE);
  assign o_row_block_count = r_row_block_count;
  assign o_count_valid     = r_count_valid;
  assign o_overrun         = r_overrun;
  assign o_count_err       = r_count_err;

endmodule
`default_nettype wire

// File: tb/tb_topk_drain.sv
`default_nettype none
// ============================================================================
// Module      : tb_topk_drain
// Description : Directed scoreboard bench for topk_drain.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_topk_drain;

  localparam int K  = 32;
  localparam int DW = 4;
  localparam int IW = 9;
  localparam int BN = 16;
  localparam int CW = 6;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              i_valid;
  logic [DW*K-1:0]   i_sorted_data;
  logic [IW*K-1:0]   i_sorted_index;
  logic              i_count_valid;
  logic [BN*CW-1:0]  i_row_block_count;
  logic              i_ready;
  logic              o_valid;
  logic [DW-1:0]     o_data;
  logic [IW-1:0]     o_index;
  logic              o_last;
  logic              o_busy;
  logic [BN*CW-1:0]  o_row_block_count;
  logic              o_count_valid;
  logic              o_overrun;
  logic              o_count_err;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [IW-1:0] i;
    logic          l;
  } exp_t;

  exp_t             q[$];
  logic [BN*CW-1:0] exp_counts;
  int               n_vec  = 0;
  int               n_miss = 0;
  int               hs;

  topk_drain dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .i_valid           (i_valid),
    .i_sorted_data     (i_sorted_data),
    .i_sorted_index    (i_sorted_index),
    .i_count_valid     (i_count_valid),
    .i_row_block_count (i_row_block_count),
    .i_ready           (i_ready),
    .o_valid           (o_valid),
    .o_data            (o_data),
    .o_index           (o_index),
    .o_last            (o_last),
    .o_busy            (o_busy),
    .o_row_block_count (o_row_block_count),
    .o_count_valid     (o_count_valid),
    .o_overrun         (o_overrun),
    .o_count_err       (o_count_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"},  o_valid, 0);
    check({tag, "_data"},   o_data, 0);
    check({tag, "_index"},  o_index, 0);
    check({tag, "_last"},   o_last, 0);
    check({tag, "_busy"},   o_busy, 0);
    check({tag, "_counts"}, o_row_block_count, 0);
    check({tag, "_cvalid"}, o_count_valid, 0);
    check({tag, "_ovr"},    o_overrun, 0);
    check({tag, "_cerr"},   o_count_err, 0);
  endtask

  // Drives one result pulse (cycle T) and its counts (cycle T+1); queues expected beats.
  task automatic launch(input bit cv, input int v);
    exp_t x;
    @(negedge clk);
    for (int e = 0; e < K; e++) begin
      i_sorted_data[e*DW +: DW]  = DW'((e + 5*v) % 16);
      i_sorted_index[e*IW +: IW] = IW'(e + 100 + 50*v);
      x.d = DW'((e + 5*v) % 16);
      x.i = IW'(e + 100 + 50*v);
      x.l = (e == K-1);
      q.push_back(x);
    end
    i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    check("busy_capt", o_busy, 1);
    check("valid_capt", o_valid, 0);
    check("counts_held", o_row_block_count, exp_counts);
    for (int b = 0; b < BN; b++) begin
      i_row_block_count[b*CW +: CW] = CW'((b + 1 + 3*v) % 64);
    end
    exp_counts    = i_row_block_count;
    i_count_valid = cv;
  endtask

  // mode 0: ready high, 1: 1,0,0,1 pattern, 2: random
  task automatic drain(input int mode, input int overrun_at, input int reset_at, output int n_hs);
    bit            done;
    bit            was_reset;
    bit            prev_stall;
    logic [DW-1:0] hd;
    logic [IW-1:0] hi;
    exp_t          x;
    n_hs = 0; done = 0; was_reset = 0; prev_stall = 0; hd = '0; hi = '0;
    for (int c = 0; c < 2000 && !done; c++) begin
      @(negedge clk);
      i_count_valid = 1'b0;
      i_valid = (c == overrun_at);
      if (c == overrun_at) begin
        i_sorted_data  = ~i_sorted_data;
        i_sorted_index = ~i_sorted_index;
      end
      case (mode)
        0:       i_ready = 1'b1;
        1:       i_ready = (c % 4 == 0) || (c % 4 == 3);
        default: i_ready = 1'($urandom_range(0, 1));
      endcase
      if (c == 0) begin
        check("first_valid", o_valid, 1);
        check("cnt_pulse", o_count_valid, 1);
        check("cnt_value", o_row_block_count, exp_counts);
      end
      if (c == 1) check("cnt_pulse_end", o_count_valid, 0);
      if (c == reset_at) begin
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        q.delete();
        done = 1; was_reset = 1;
      end else if (!o_valid) begin
        check("valid_hold", o_valid, 1);
      end else begin
        if (prev_stall) begin
          check("stall_data", o_data, hd);
          check("stall_index", o_index, hi);
        end
        if (i_ready) begin
          x = q.pop_front();
          check("beat_data", o_data, x.d);
          check("beat_index", o_index, x.i);
          check("beat_last", o_last, x.l);
          n_hs++;
          prev_stall = 0;
          if (x.l) done = 1;
        end else begin
          prev_stall = 1; hd = o_data; hi = o_index;
        end
      end
    end
    i_valid = 1'b0;
    if (!done) check("timeout_beats", n_hs, K);
    if (!was_reset) begin
      @(negedge clk);
      i_ready = 1'b0;
      check("busy_after", o_busy, 0);
      check("valid_after", o_valid, 0);
    end
  endtask

  initial begin
    rst_n = 1'b0; i_valid = 1'b0; i_count_valid = 1'b0; i_ready = 1'b0;
    i_sorted_data = '0; i_sorted_index = '0; i_row_block_count = '0;
    exp_counts = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    launch(1, 0); drain(0, -1, -1, hs);
    check("basic_hs", hs, K);
    check("basic_ovr", o_overrun, 0);
    check("basic_cerr", o_count_err, 0);

    launch(1, 1); drain(1, -1, -1, hs);
    check("pattern_hs", hs, K);

    launch(1, 2); drain(2, -1, -1, hs);
    check("random_hs", hs, K);

    launch(1, 0); drain(0, 8, -1, hs);
    check("overrun_hs", hs, K);
    check("overrun_flag", o_overrun, 1);
    launch(1, 1); drain(0, -1, -1, hs);
    check("after_ovr_hs", hs, K);
    check("overrun_sticky", o_overrun, 1);
    check("cerr_clean", o_count_err, 0);

    launch(0, 2); drain(0, -1, -1, hs);
    check("cerr_hs", hs, K);
    check("cerr_flag", o_count_err, 1);

    launch(1, 0); drain(0, -1, 5, hs);
    check("rst_beats", hs, 5);
    @(negedge clk);
    rst_n = 1'b1;
    exp_counts = '0;
    check_reset_outputs("post_rst");
    launch(1, 1); drain(0, -1, -1, hs);
    check("post_rst_hs", hs, K);
    check("post_rst_ovr", o_overrun, 0);
    check("post_rst_cerr", o_count_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
